// File: rtl/mult_div_pkg.sv
// Shared types for the iterative multiply/divide unit: controller states and op encodings.
package mult_div_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MULT,
        DIV,
        FIX,
        DONE
    } stateT;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

endpackage

// File: rtl/mult_div_negate.sv
// Conditional two's-complement negation: produces operand magnitudes and applies result signs.
module mult_div_negate #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             negate,
    output logic [WIDTH-1:0] result
);

    assign result = negate ? ((~value) + WIDTH'(1)) : value;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative shift-add multiplier / restoring divider, one step per cycle.
// Build option: define MULT_DIV_UNSIGNED_EN to honour is_unsigned (otherwise every operation is signed).
//
// state | meaning
// IDLE  | waiting for start
// MULT  | one shift-add step per cycle on operand magnitudes
// DIV   | one restoring subtract-shift step per cycle
// FIX   | sign correction; results written on the exit edge
// DONE  | done pulse; start may be accepted again here
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic             is_unsigned,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    stateT            state, nextState, launchState;
    logic [CNT_W-1:0] count;
    logic             opReg;
    logic [WIDTH-1:0] bReg, accHi, accLo;
    logic             negLo, negHi;
    logic             signedOp, divByZero;
    logic [WIDTH-1:0] aMag, bMag;
    logic [WIDTH:0]   mulSum, divShift, divDiff;
    logic [2*WIDTH-1:0] prodFix;
    logic [WIDTH-1:0] quotFix, remFix, fixHi, fixLo;

`ifdef MULT_DIV_UNSIGNED_EN
    assign signedOp = ~is_unsigned;
`else
    assign signedOp = 1'b1;
`endif

    assign divByZero = (op == OP_DIV) && (b_in == '0);

    mult_div_negate #(.WIDTH(WIDTH)) uNegA (
        .value(a_in), .negate(signedOp & a_in[WIDTH-1]), .result(aMag)
    );
    mult_div_negate #(.WIDTH(WIDTH)) uNegB (
        .value(b_in), .negate(signedOp & b_in[WIDTH-1]), .result(bMag)
    );
    mult_div_negate #(.WIDTH(2*WIDTH)) uNegProd (
        .value({accHi, accLo}), .negate(negLo), .result(prodFix)
    );
    mult_div_negate #(.WIDTH(WIDTH)) uNegQuot (
        .value(accLo), .negate(negLo), .result(quotFix)
    );
    mult_div_negate #(.WIDTH(WIDTH)) uNegRem (
        .value(accHi), .negate(negHi), .result(remFix)
    );

    assign fixHi = (opReg == OP_MULT) ? prodFix[2*WIDTH-1:WIDTH] : remFix;
    assign fixLo = (opReg == OP_MULT) ? prodFix[WIDTH-1:0]       : quotFix;

    assign mulSum   = {1'b0, accHi} + (accLo[0] ? {1'b0, bReg} : '0);
    assign divShift = {accHi, accLo[WIDTH-1]};
    assign divDiff  = divShift - {1'b0, bReg};

    assign busy = (state == MULT) || (state == DIV) || (state == FIX);
    assign done = (state == DONE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState   = state;
        launchState = (op == OP_MULT) ? MULT : (divByZero ? DONE : DIV);
        case (state)
            IDLE:     if (start) nextState = launchState;
            MULT,
            DIV:      if (count == CNT_W'(1)) nextState = FIX;
            FIX:      nextState = DONE;
            DONE:     nextState = start ? launchState : IDLE;
            default:  nextState = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count    <= '0;
            opReg    <= 1'b0;
            bReg     <= '0;
            accHi    <= '0;
            accLo    <= '0;
            negLo    <= 1'b0;
            negHi    <= 1'b0;
            hi_out   <= '0;
            lo_out   <= '0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        opReg <= op;
                        count <= CNT_W'(WIDTH);
                        accHi <= '0;
                        negLo <= signedOp & (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
                        negHi <= signedOp & a_in[WIDTH-1];
                        // Multiply shifts the multiplier out of accLo; divide shifts the dividend out.
                        if (op == OP_MULT) begin
                            bReg  <= aMag;
                            accLo <= bMag;
                        end else begin
                            bReg  <= bMag;
                            accLo <= aMag;
                        end
                        if (divByZero) div_zero <= 1'b1;
                    end
                end
                MULT: begin
                    count <= count - CNT_W'(1);
                    accHi <= mulSum[WIDTH:1];
                    accLo <= {mulSum[0], accLo[WIDTH-1:1]};
                end
                DIV: begin
                    count <= count - CNT_W'(1);
                    if (!divDiff[WIDTH]) begin
                        accHi <= divDiff[WIDTH-1:0];
                        accLo <= {accLo[WIDTH-2:0], 1'b1};
                    end else begin
                        accHi <= divShift[WIDTH-1:0];
                        accLo <= {accLo[WIDTH-2:0], 1'b0};
                    end
                end
                FIX: begin
                    hi_out   <= fixHi;
                    lo_out   <= fixLo;
                    div_zero <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit (WIDTH=32): directed corner cases plus randomized ops vs. an arithmetic model.
module tb_mult_div_unit;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         op = 1'b0;
    logic         is_unsigned = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic [W-1:0] hi_out, lo_out;
    logic         busy, done, div_zero;

    int assertCount = 0;
    int failCount   = 0;

    logic [W-1:0] expHi = '0;
    logic [W-1:0] expLo = '0;
    logic         expDz = 1'b0;

    mult_div_unit #(.WIDTH(W)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op), .is_unsigned(is_unsigned),
        .a_in(a_in), .b_in(b_in), .hi_out(hi_out), .lo_out(lo_out),
        .busy(busy), .done(done), .div_zero(div_zero)
    );

    always #5 clock = ~clock;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void refModel(input logic o, input logic u, input logic [W-1:0] a,
                                     input logic [W-1:0] b, input logic [W-1:0] prevHi,
                                     input logic [W-1:0] prevLo, output logic [W-1:0] h,
                                     output logic [W-1:0] l, output logic dz);
        logic        effU;
        logic [63:0] p;
        longint      sa, sb, q, r;
`ifdef MULT_DIV_UNSIGNED_EN
        effU = u;
`else
        effU = 1'b0;
        if (u) effU = 1'b0;
`endif
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        h  = prevHi;
        l  = prevLo;
        dz = 1'b0;
        if (!o) begin
            if (effU) p = {32'b0, a} * {32'b0, b};
            else      p = sa * sb;
            h = p[63:32];
            l = p[31:0];
        end else if (b == '0) begin
            dz = 1'b1;
        end else if (effU) begin
            l = a / b;
            h = a % b;
        end else begin
            q = sa / sb;
            r = sa % sb;
            l = q[31:0];
            h = r[31:0];
        end
    endfunction

    // Called at a negedge; returns at the negedge where done is seen high.
    task automatic runOp(input logic o, input logic u, input logic [W-1:0] a, input logic [W-1:0] b);
        int           cycles;
        logic         heldOk;
        logic         zeroDiv;
        logic [W-1:0] nh, nl;
        logic         ndz;
        refModel(o, u, a, b, expHi, expLo, nh, nl, ndz);
        zeroDiv = o && (b == '0);
        op = o; is_unsigned = u; a_in = a; b_in = b; start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        op = 1'($urandom); is_unsigned = 1'($urandom); a_in = $urandom; b_in = $urandom;
        if (!zeroDiv) checkVal("busyAfterAccept", busy, 1);
        cycles = 0;
        heldOk = 1'b1;
        while (!done && cycles < 200) begin
            if (hi_out !== expHi || lo_out !== expLo) heldOk = 1'b0;
            start = (cycles == 3);
            @(negedge clock);
            cycles++;
        end
        start = 1'b0;
        // done follows the accept edge by WIDTH+1 edges, or immediately on divide by zero
        checkVal("latency", 64'(cycles), zeroDiv ? 64'd0 : 64'(W + 1));
        checkVal("holdWhileBusy", heldOk, 1);
        checkVal("done", done, 1);
        checkVal("busyAtDone", busy, 0);
        checkVal("hi", hi_out, nh);
        checkVal("lo", lo_out, nl);
        checkVal("divZero", div_zero, ndz);
        expHi = nh; expLo = nl; expDz = ndz;
    endtask

    task automatic idleCheck();
        @(negedge clock);
        checkVal("donePulse", done, 0);
        checkVal("idleBusy", busy, 0);
        checkVal("idleHi", hi_out, expHi);
        checkVal("idleLo", lo_out, expLo);
        checkVal("idleDivZero", div_zero, expDz);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic         o, u, seen;
        logic [W-1:0] a, b;

        #2 reset = 1'b0;
        #1;
        checkVal("rstHi", hi_out, 0);
        checkVal("rstLo", lo_out, 0);
        checkVal("rstBusy", busy, 0);
        checkVal("rstDone", done, 0);
        checkVal("rstDivZero", div_zero, 0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        runOp(1'b0, 1'b0, 32'd7, 32'hFFFF_FFFD);
        checkVal("mul7xm3Hi", hi_out, 32'hFFFF_FFFF);
        checkVal("mul7xm3Lo", lo_out, 32'hFFFF_FFEB);
        idleCheck();

        runOp(1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2);
        checkVal("divm7by2Lo", lo_out, 32'hFFFF_FFFD);
        checkVal("divm7by2Hi", hi_out, 32'hFFFF_FFFF);
        idleCheck();

        runOp(1'b1, 1'b0, 32'd5, 32'd0);
        checkVal("div0Flag", div_zero, 1);
        checkVal("div0KeepLo", lo_out, 32'hFFFF_FFFD);
        idleCheck();

        runOp(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
        checkVal("minByM1Lo", lo_out, 32'h8000_0000);
        checkVal("minByM1Hi", hi_out, 32'h0);
        // back-to-back: start accepted in the DONE cycle
        runOp(1'b0, 1'b1, 32'hFFFF_FFFF, 32'd2);
`ifdef MULT_DIV_UNSIGNED_EN
        checkVal("unsMulHi", hi_out, 32'h1);
`else
        checkVal("unsMulHi", hi_out, 32'hFFFF_FFFF);
`endif
        checkVal("unsMulLo", lo_out, 32'hFFFF_FFFE);
        idleCheck();

        op = 1'b0; is_unsigned = 1'b0; a_in = 32'd12345; b_in = 32'd678; start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(negedge clock);
        reset = 1'b0;
        #1;
        checkVal("midRstHi", hi_out, 0);
        checkVal("midRstLo", lo_out, 0);
        checkVal("midRstBusy", busy, 0);
        checkVal("midRstDone", done, 0);
        checkVal("midRstDivZero", div_zero, 0);
        expHi = '0; expLo = '0; expDz = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clock);
            if (done || busy) seen = 1'b1;
        end
        checkVal("noDoneAfterRst", seen, 0);
        runOp(1'b0, 1'b0, 32'd12345, 32'd678);
        idleCheck();

        for (int i = 0; i < 40; i++) begin
            o = 1'($urandom_range(0, 1));
            u = 1'($urandom_range(0, 1));
            a = pick();
            b = pick();
            if (o && $urandom_range(0, 5) == 0) b = '0;
            runOp(o, u, a, b);
            if ($urandom_range(0, 2) != 0) idleCheck();
        end
        idleCheck();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
